if_stage: RTL and testbench
===========================

Name: if_stage

Overview:
- Instruction-fetch stage directly upstream of the ID stage.
- Owns the PC register and the instruction-memory request/ready handshake.
- Owns the IF/ID pipeline register that drives the ID stage's instruction and pcPlus4 inputs.
- Honours hazard-unit stalls and branch redirects resolved in ID (target from the ID branch adder, taken = controller decision on the ID comparator).

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
stall  input  1  hazard unit: hold IF/ID and PC
redirect  input  1  controller: branch/jump taken in ID this cycle
redirect_target  input  32  new PC (ID branch adder output)
imem_addr  output  32  fetch address (= PC register)
imem_req  output  1  fetch request
imem_ready  input  1  memory response; handshake completes when imem_req & imem_ready
imem_rdata  input  32  instruction word, valid in the handshake cycle
instruction  output  32  IF/ID instruction to ID stage
pcPlus4  output  32  IF/ID PC+4 to ID stage
valid_id  output  1  IF/ID holds a real instruction

Behaviour:
- Reset (synchronous, rst=1 at edge): PC=RESET_PC, state=FETCH, instruction=32'h0, pcPlus4=32'h0, valid_id=0, hold buffer and saved target cleared. Reset overrides every other input, in any state.
- Bubble: valid_id=0 always comes with instruction=32'h0 (sll $0 NOP). pcPlus4 is left unchanged on a bubble.
- Memory contract: once imem_req=1, imem_addr and imem_req stay stable until handshake. Zero-wait memory ties imem_ready=1.
- All PC arithmetic is modulo 2^32; PC+4 wraps to 0.
- Precedence within each state: redirect > stall > normal.
- FETCH state (imem_req=1):
  - redirect & handshake: drop rdata; PC<=redirect_target; IF/ID<=bubble; stay FETCH.
  - redirect & no handshake: save redirect_target; IF/ID<=bubble; go to DISCARD.
  - stall & handshake: hold buffer<={rdata, PC+4}; PC<=PC+4; IF/ID held; go to HOLD.
  - stall & no handshake: all held.
  - normal & handshake: IF/ID<={rdata, PC+4, valid=1}; PC<=PC+4.
  - normal & no handshake: IF/ID<=bubble.
- HOLD state (imem_req=0):
  - redirect: discard buffer; PC<=redirect_target; IF/ID<=bubble; go to FETCH.
  - stall: all held.
  - else: IF/ID<={buffer, valid=1}; go to FETCH. The next request issues the following cycle.
- DISCARD state (imem_req=1, imem_addr=old PC):
  - A further redirect overwrites the saved target (last one wins).
  - On handshake: drop rdata; PC<=saved target; go to FETCH.
  - IF/ID stays bubble; stall has no visible effect.
- Zero-wait steady state: one instruction per cycle, one-cycle latency from handshake to IF/ID.
- A taken branch costs exactly 1 bubble with zero-wait memory.
- Controller never asserts redirect and stall together; if both arrive, redirect wins as specified above.

Decomposition:
- Shared package (pipeline_pkg):
  - fetch state encoding FETCH/HOLD/DISCARD (2 bits)
  - NOP_INSTR = 32'h0
  - default RESET_PC
  - PC_INC = 4
- Natural sub-module: if_id_reg.
  - Holds {instruction, pcPlus4, valid} with load, hold and flush controls.
  - Reusable for the later ID/EX register.
- FSM, PC and hold buffer stay in if_stage.

Test Plan:
- Reset, zero-wait sequential fetch:
  - Stimulus: rst=1 then 0, imem_ready=1, rdata=addr-derived.
  - Response: imem_addr 0,4,8; next cycles pcPlus4 4,8,12, valid_id=1; mid-run rst=1 gives PC=0, valid_id=0 next cycle.
- Wait states:
  - Stimulus: imem_ready low 2 cycles at addr 0x10.
  - Response: imem_addr held at 0x10; valid_id=0 during the wait; after ready, instruction=rdata, pcPlus4=0x14.
- Stall with completion:
  - Stimulus: stall=1 at handshake of addr 0x20 with rdata=0x8C220004, stall held 2 cycles.
  - Response: imem_req=0 in HOLD; IF/ID unchanged; on release instruction=0x8C220004, pcPlus4=0x24, then fetch 0x24.
- Redirect during wait:
  - Stimulus: redirect target 0x100 while 0x30 is pending, second redirect 0x200 next cycle, ready 2 cycles later.
  - Response: rdata dropped; next imem_addr=0x200; instruction=0 and valid_id=0 throughout.
- Zero-wait branch:
  - Stimulus: redirect target 0x40 while fetching 0x0C.
  - Response: exactly one bubble, then instruction from 0x40, pcPlus4=0x44.
- Wrap and precedence:
  - PC=0xFFFFFFFC fetch gives pcPlus4=0x0.
  - redirect & stall together: flush and load target.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions.
// Holds the fetch-FSM state encoding, the bubble instruction word, the default
// reset PC and the PC increment used by the fetch stage.
package pipeline_pkg;

  // Fetch-stage FSM states:
  // FETCH   - request outstanding at the PC
  // HOLD    - word captured while ID was stalled; no request
  // DISCARD - a redirect arrived before the request completed, so the
  //           returning word is dropped
  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    HOLD    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_t;

  // sll $0,$0,0 encodes as all zeros. It is used as the bubble word.
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] PC_INC           = 32'd4;

  // Sequential PC. The sum wraps modulo 2^32.
  function automatic logic [31:0] pc_plus_inc(input logic [31:0] pc);
    return pc + PC_INC;
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// Pipeline register that carries {instruction, pcPlus4, valid} between stages.
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   load                capture load_instr/load_pc4 and mark the entry valid
//   flush               insert a bubble: NOP, valid=0, pc4 left unchanged
//   load_instr/load_pc4 data to capture on load
//   instruction/pc4     registered outputs
//   valid               the register holds a real instruction
//
// Control priority is rst > flush > load. With no control asserted, the
// register holds its contents, which gives the stall behaviour.
module if_id_reg
  import pipeline_pkg::*;
#(
  parameter int INSTR_W = 32,
  parameter int PC_W    = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               flush,
  input  logic [INSTR_W-1:0] load_instr,
  input  logic [PC_W-1:0]    load_pc4,
  output logic [INSTR_W-1:0] instruction,
  output logic [PC_W-1:0]    pc4,
  output logic               valid
);

  logic [INSTR_W-1:0] instr_reg;
  logic [PC_W-1:0]    pc4_reg;
  logic               valid_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      instr_reg <= INSTR_W'(NOP_INSTR);
      pc4_reg   <= '0;
      valid_reg <= 1'b0;
    end else if (flush) begin
      // A bubble always carries the NOP word. The PC field is left alone.
      instr_reg <= INSTR_W'(NOP_INSTR);
      valid_reg <= 1'b0;
    end else if (load) begin
      instr_reg <= load_instr;
      pc4_reg   <= load_pc4;
      valid_reg <= 1'b1;
    end
  end

  assign instruction = instr_reg;
  assign pc4         = pc4_reg;
  assign valid       = valid_reg;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage.
// Owns the PC, the instruction-memory request/ready handshake, a one-entry
// hold buffer for words that complete while ID is stalled, and the IF/ID
// pipeline register.
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   stall             hazard unit: hold IF/ID and PC
//   redirect          controller: branch/jump taken in ID this cycle
//   redirect_target   new PC from the ID branch adder
//   imem_addr         fetch address (the PC register)
//   imem_req          fetch request; stays stable until the handshake
//   imem_ready        memory response; handshake = imem_req & imem_ready
//   imem_rdata        instruction word, valid in the handshake cycle
//   instruction       IF/ID instruction to ID
//   pcPlus4           IF/ID PC+4 to ID
//   valid_id          IF/ID holds a real instruction
module if_stage
  import pipeline_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic [31:0] imem_addr,
  output logic        imem_req,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic [31:0] pcPlus4,
  output logic        valid_id
);

  fetch_state_t state_reg, state_next;

  logic [31:0] pc_reg, pc_next;
  logic [31:0] buf_instr_reg, buf_instr_next;
  logic [31:0] buf_pc4_reg, buf_pc4_next;
  logic [31:0] saved_target_reg, saved_target_next;

  logic        handshake;
  logic [31:0] pc_inc;

  logic        ifid_load;
  logic        ifid_flush;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc4;

  assign pc_inc    = pc_plus_inc(pc_reg);
  assign handshake = imem_req & imem_ready;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= FETCH;
      pc_reg           <= RESET_PC;
      buf_instr_reg    <= NOP_INSTR;
      buf_pc4_reg      <= 32'h0;
      saved_target_reg <= 32'h0;
    end else begin
      state_reg        <= state_next;
      pc_reg           <= pc_next;
      buf_instr_reg    <= buf_instr_next;
      buf_pc4_reg      <= buf_pc4_next;
      saved_target_reg <= saved_target_next;
    end
  end

  // Next-state logic. Priority is redirect > stall > normal.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      FETCH: begin
        if (redirect) begin
          // If the word has not arrived, the request must still complete,
          // so switch to DISCARD and drop the word when it returns.
          state_next = handshake ? FETCH : DISCARD;
        end else if (stall && handshake) begin
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (redirect || !stall) begin
          state_next = FETCH;
        end
      end
      DISCARD: begin
        if (handshake) begin
          state_next = FETCH;
        end
      end
      default: state_next = FETCH;
    endcase
  end

  // Output and datapath control
  always_comb begin
    imem_req          = (state_reg != HOLD);
    pc_next           = pc_reg;
    buf_instr_next    = buf_instr_reg;
    buf_pc4_next      = buf_pc4_reg;
    saved_target_next = saved_target_reg;
    ifid_load         = 1'b0;
    ifid_flush        = 1'b0;
    ifid_instr        = imem_rdata;
    ifid_pc4          = pc_inc;

    case (state_reg)
      FETCH: begin
        if (redirect) begin
          ifid_flush = 1'b1;
          if (handshake) begin
            pc_next = redirect_target;
          end else begin
            saved_target_next = redirect_target;
          end
        end else if (stall) begin
          // ID cannot take the word, so park it and advance the PC.
          // The request ends here, which keeps the handshake contract intact.
          if (handshake) begin
            buf_instr_next = imem_rdata;
            buf_pc4_next   = pc_inc;
            pc_next        = pc_inc;
          end
        end else if (handshake) begin
          ifid_load = 1'b1;
          pc_next   = pc_inc;
        end else begin
          ifid_flush = 1'b1;
        end
      end
      HOLD: begin
        if (redirect) begin
          ifid_flush = 1'b1;
          pc_next    = redirect_target;
        end else if (!stall) begin
          ifid_load  = 1'b1;
          ifid_instr = buf_instr_reg;
          ifid_pc4   = buf_pc4_reg;
        end
      end
      DISCARD: begin
        // imem_addr stays at the old PC until the stale word returns.
        // The most recent redirect target is the one used.
        ifid_flush = 1'b1;
        if (redirect) begin
          saved_target_next = redirect_target;
        end
        if (handshake) begin
          pc_next = saved_target_next;
        end
      end
      default: begin
        ifid_flush = 1'b1;
      end
    endcase
  end

  assign imem_addr = pc_reg;

  if_id_reg #(
    .INSTR_W (32),
    .PC_W    (32)
  ) u_if_id_reg (
    .clk         (clk),
    .rst         (rst),
    .load        (ifid_load),
    .flush       (ifid_flush),
    .load_instr  (ifid_instr),
    .load_pc4    (ifid_pc4),
    .instruction (instruction),
    .pc4         (pcPlus4),
    .valid       (valid_id)
  );

endmodule

// File: tb/tb_if_stage.sv
// Directed testbench for if_stage.
// The memory returns addr + 0x1000_0000 unless a test supplies a specific word.
module tb_if_stage;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_target;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] instruction;
  logic [31:0] pcPlus4;
  logic        valid_id;

  logic        rdata_ovr_en;
  logic [31:0] rdata_ovr;

  int n_checks;
  int n_fail;

  if_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .imem_addr       (imem_addr),
    .imem_req        (imem_req),
    .imem_ready      (imem_ready),
    .imem_rdata      (imem_rdata),
    .instruction     (instruction),
    .pcPlus4         (pcPlus4),
    .valid_id        (valid_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign imem_rdata = rdata_ovr_en ? rdata_ovr : (imem_addr + 32'h1000_0000);

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  // Advance one clock edge and settle, so outputs are sampled away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_ifid(input string tag, input logic [31:0] ins,
                            input logic [31:0] p4, input logic v);
    check_val({tag, ".instr"}, instruction, ins);
    check_val({tag, ".pc4"}, pcPlus4, p4);
    check_val({tag, ".valid"}, {31'h0, valid_id}, {31'h0, v});
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    rst = 1'b1;
    stall = 1'b0;
    redirect = 1'b0;
    redirect_target = 32'h0;
    imem_ready = 1'b1;
    rdata_ovr_en = 1'b0;
    rdata_ovr = 32'h0;

    // Reset state
    tick();
    tick();
    check_ifid("reset", 32'h0, 32'h0, 1'b0);
    check_val("reset.addr", imem_addr, 32'h0);
    check_val("reset.req", {31'h0, imem_req}, 32'h1);

    // Zero-wait sequential fetch
    rst = 1'b0;
    tick();
    check_val("seq0.addr", imem_addr, 32'h4);
    check_ifid("seq0", 32'h1000_0000, 32'h4, 1'b1);
    tick();
    check_val("seq1.addr", imem_addr, 32'h8);
    check_ifid("seq1", 32'h1000_0004, 32'h8, 1'b1);
    tick();
    check_ifid("seq2", 32'h1000_0008, 32'hC, 1'b1);

    // Reset in the middle of a run
    rst = 1'b1;
    tick();
    check_val("midrst.addr", imem_addr, 32'h0);
    check_ifid("midrst", 32'h0, 32'h0, 1'b0);
    rst = 1'b0;

    // Zero-wait branch taken while fetching 0x0C
    tick();
    tick();
    tick();
    check_val("br.pre_addr", imem_addr, 32'hC);
    redirect = 1'b1;
    redirect_target = 32'h40;
    tick();
    redirect = 1'b0;
    check_val("br.addr", imem_addr, 32'h40);
    check_ifid("br.bubble", 32'h0, 32'hC, 1'b0);
    tick();
    check_ifid("br.target", 32'h1000_0040, 32'h44, 1'b1);

    // Wait states at 0x10
    redirect = 1'b1;
    redirect_target = 32'h10;
    tick();
    redirect = 1'b0;
    imem_ready = 1'b0;
    tick();
    check_val("ws1.addr", imem_addr, 32'h10);
    check_val("ws1.req", {31'h0, imem_req}, 32'h1);
    check_ifid("ws1", 32'h0, 32'h44, 1'b0);
    tick();
    check_val("ws2.addr", imem_addr, 32'h10);
    check_val("ws2.valid", {31'h0, valid_id}, 32'h0);
    imem_ready = 1'b1;
    tick();
    check_val("ws3.addr", imem_addr, 32'h14);
    check_ifid("ws3", 32'h1000_0010, 32'h14, 1'b1);

    // Stall when the handshake at 0x20 completes
    redirect = 1'b1;
    redirect_target = 32'h20;
    tick();
    redirect = 1'b0;
    stall = 1'b1;
    rdata_ovr_en = 1'b1;
    rdata_ovr = 32'h8C22_0004;
    tick();
    rdata_ovr_en = 1'b0;
    check_val("st1.req", {31'h0, imem_req}, 32'h0);
    check_val("st1.addr", imem_addr, 32'h24);
    check_ifid("st1", 32'h0, 32'h14, 1'b0);
    tick();
    check_val("st2.req", {31'h0, imem_req}, 32'h0);
    check_ifid("st2", 32'h0, 32'h14, 1'b0);
    stall = 1'b0;
    tick();
    check_ifid("st3", 32'h8C22_0004, 32'h24, 1'b1);
    check_val("st3.req", {31'h0, imem_req}, 32'h1);
    check_val("st3.addr", imem_addr, 32'h24);
    tick();
    check_ifid("st4", 32'h1000_0024, 32'h28, 1'b1);

    // Redirects while the request at 0x30 is waiting
    redirect = 1'b1;
    redirect_target = 32'h30;
    tick();
    redirect = 1'b0;
    imem_ready = 1'b0;
    tick();
    redirect = 1'b1;
    redirect_target = 32'h100;
    tick();
    check_val("rd1.addr", imem_addr, 32'h30);
    check_val("rd1.req", {31'h0, imem_req}, 32'h1);
    check_ifid("rd1", 32'h0, 32'h28, 1'b0);
    redirect_target = 32'h200;
    tick();
    redirect = 1'b0;
    tick();
    check_val("rd2.addr", imem_addr, 32'h30);
    check_val("rd2.instr", instruction, 32'h0);
    imem_ready = 1'b1;
    tick();
    check_val("rd3.addr", imem_addr, 32'h200);
    check_ifid("rd3", 32'h0, 32'h28, 1'b0);
    tick();
    check_ifid("rd4", 32'h1000_0200, 32'h204, 1'b1);

    // PC+4 wraps to zero
    redirect = 1'b1;
    redirect_target = 32'hFFFF_FFFC;
    tick();
    redirect = 1'b0;
    tick();
    check_val("wrap.addr", imem_addr, 32'h0);
    check_ifid("wrap", 32'h0FFF_FFFC, 32'h0, 1'b1);

    // Redirect and stall together in FETCH: the redirect wins
    redirect = 1'b1;
    stall = 1'b1;
    redirect_target = 32'h80;
    tick();
    redirect = 1'b0;
    stall = 1'b0;
    check_val("prec1.addr", imem_addr, 32'h80);
    check_ifid("prec1", 32'h0, 32'h0, 1'b0);
    tick();
    check_ifid("prec2", 32'h1000_0080, 32'h84, 1'b1);

    // Redirect and stall together in HOLD
    stall = 1'b1;
    tick();
    check_val("prec3.req", {31'h0, imem_req}, 32'h0);
    redirect = 1'b1;
    redirect_target = 32'h300;
    tick();
    redirect = 1'b0;
    stall = 1'b0;
    check_val("prec4.req", {31'h0, imem_req}, 32'h1);
    check_val("prec4.addr", imem_addr, 32'h300);
    check_ifid("prec4", 32'h0, 32'h84, 1'b0);
    tick();
    check_ifid("prec5", 32'h1000_0300, 32'h304, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
